// File: rtl/sim_test_monitor_pkg.sv
// Shared types and constants for the riscv-tests run monitor.
package sim_test_monitor_pkg;

    // Encoding doubles as the status output value.
    typedef enum logic [2:0] {
        StHold    = 3'd0,
        StRun     = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StTimeout = 3'd4,
        StWdog    = 3'd5
    } mon_state_e;

    localparam logic [31:0] InstEcall = 32'h0000_0073;
    localparam int unsigned GpPass    = 1;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sim_test_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sim_test_monitor_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sim_test_monitor.sv
// Run controller for riscv-tests: sequences core reset, counts cycles/retires,
// detects end-of-test (ECALL, self-loop, timeout, watchdog) and holds a sticky verdict.
module sim_test_monitor
    import sim_test_monitor_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned RESET_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned LOOP_LIMIT     = 4,
    parameter int unsigned WDOG_CYCLES    = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             core_reset,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic [31:0]      retire_inst,
    input  logic [XLEN-1:0]  gp_value,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic             done,
    output logic             pass,
    output logic [2:0]       status,
    output logic [XLEN-1:0]  fail_testnum
);

    localparam int unsigned RstEff = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
    localparam int unsigned HoldW  = cnt_width(RstEff);
    localparam int unsigned LoopW  = cnt_width(LOOP_LIMIT);
    localparam int unsigned WdogW  = cnt_width(WDOG_CYCLES);

    localparam logic [HoldW-1:0] HoldLast    = HoldW'(RstEff - 1);
    localparam logic [LoopW-1:0] LoopHit     = LoopW'(LOOP_LIMIT - 2);
    localparam logic [WdogW-1:0] WdogLast    = WdogW'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_e state_q, state_d;
    logic [XLEN-1:0] last_pc_q;
    logic [XLEN-1:0] fail_testnum_q, fail_testnum_d;

    logic [HoldW-1:0] hold_cnt;
    logic [LoopW-1:0] loop_cnt;
    logic [WdogW-1:0] wdog_cnt;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    logic in_hold, in_run, retire, pc_match;
    logic trig_ecall, trig_loop, trig_timeout, trig_wdog;

    assign in_hold  = (state_q == StHold);
    assign in_run   = (state_q == StRun);
    assign retire   = in_run && retire_valid;
    assign pc_match = (retire_pc == last_pc_q);

    sim_test_monitor_sat_counter #(.Width(HoldW)) u_hold_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .inc     (in_hold),
        .count   (hold_cnt)
    );

    sim_test_monitor_sat_counter #(.Width(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .inc     (in_run),
        .count   (cycle_cnt)
    );

    sim_test_monitor_sat_counter #(.Width(CNT_W)) u_retire_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .inc     (retire),
        .count   (retire_cnt)
    );

    // Counts repeats beyond the first retire at a given pc.
    sim_test_monitor_sat_counter #(.Width(LoopW)) u_loop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (retire && !pc_match),
        .inc     (retire && pc_match),
        .count   (loop_cnt)
    );

    sim_test_monitor_sat_counter #(.Width(WdogW)) u_wdog_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (retire),
        .inc     (in_run && !retire_valid),
        .count   (wdog_cnt)
    );

    assign trig_ecall   = retire && (retire_inst == InstEcall);
    assign trig_loop    = retire && pc_match && (loop_cnt == LoopHit);
    assign trig_timeout = in_run && (cycle_cnt == TimeoutLast);
    assign trig_wdog    = in_run && !retire_valid && (wdog_cnt == WdogLast);

    always_comb begin
        state_d        = state_q;
        fail_testnum_d = fail_testnum_q;
        unique case (state_q)
            StHold: begin
                if (hold_cnt == HoldLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (trig_ecall || trig_loop) begin
                    if (gp_value == XLEN'(GpPass)) begin
                        state_d = StPass;
                    end else begin
                        state_d        = StFail;
                        fail_testnum_d = gp_value >> 1;
                    end
                end else if (trig_timeout) begin
                    state_d = StTimeout;
                end else if (trig_wdog) begin
                    state_d = StWdog;
                end
            end
            default: begin
                // Terminal verdicts hold until reset_n.
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StHold;
            last_pc_q      <= '0;
            fail_testnum_q <= '0;
        end else begin
            state_q        <= state_d;
            fail_testnum_q <= fail_testnum_d;
            if (retire) begin
                last_pc_q <= retire_pc;
            end
        end
    end

    assign core_reset   = in_hold;
    assign done         = !in_hold && !in_run;
    assign pass         = (state_q == StPass);
    assign status       = 3'(state_q);
    assign fail_testnum = fail_testnum_q;
    assign cycle_count  = cycle_cnt;
    assign retire_count = retire_cnt;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Randomized and directed bench for sim_test_monitor against a run-level reference model.
module tb_sim_test_monitor;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned CNT_W          = 32;
    localparam int unsigned RESET_CYCLES   = 2;
    localparam int unsigned TIMEOUT_CYCLES = 300;
    localparam int unsigned LOOP_LIMIT     = 4;
    localparam int unsigned WDOG_CYCLES    = 64;
    localparam logic [31:0] ECALL          = 32'h0000_0073;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             core_reset;
    logic             retire_valid = 1'b0;
    logic [XLEN-1:0]  retire_pc = '0;
    logic [31:0]      retire_inst = '0;
    logic [XLEN-1:0]  gp_value = '0;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;
    logic             done;
    logic             pass;
    logic [2:0]       status;
    logic [XLEN-1:0]  fail_testnum;

    always #5 clk = ~clk;

    sim_test_monitor #(
        .XLEN           (XLEN),
        .CNT_W          (CNT_W),
        .RESET_CYCLES   (RESET_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .LOOP_LIMIT     (LOOP_LIMIT),
        .WDOG_CYCLES    (WDOG_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .core_reset   (core_reset),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_inst  (retire_inst),
        .gp_value     (gp_value),
        .cycle_count  (cycle_count),
        .retire_count (retire_count),
        .done         (done),
        .pass         (pass),
        .status       (status),
        .fail_testnum (fail_testnum)
    );

    int n_cmp = 0;
    int n_err = 0;
    string tag = "init";

    // Reference model: verdict 0=hold 1=run 2=pass 3=fail 4=timeout 5=wdog.
    int          m_state;
    int unsigned m_hold, m_cyc, m_ret, m_streak, m_idle;
    logic [31:0] m_last, m_testnum;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_hold    = 0;
        m_cyc     = 0;
        m_ret     = 0;
        m_idle    = 0;
        m_last    = '0;
        m_streak  = 1;  // last pc starts at 0 as if one retire at pc 0 already happened
        m_testnum = '0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] gp);
        bit is_ecall, is_loop, is_tmo, is_wd;
        if (m_state == 0) begin
            m_hold++;
            if (m_hold >= RESET_CYCLES) m_state = 1;
        end else if (m_state == 1) begin
            is_ecall = v && (inst == ECALL);
            is_loop  = v && (pc == m_last) && (m_streak + 1 == LOOP_LIMIT);
            is_tmo   = (m_cyc + 1 == TIMEOUT_CYCLES);
            is_wd    = !v && (m_idle + 1 == WDOG_CYCLES);
            m_cyc++;
            if (v) begin
                m_ret++;
                m_streak = (pc == m_last) ? m_streak + 1 : 1;
                m_last   = pc;
                m_idle   = 0;
            end else begin
                m_idle++;
            end
            if (is_ecall || is_loop) begin
                if (gp == 32'd1) begin
                    m_state = 2;
                end else begin
                    m_state   = 3;
                    m_testnum = gp >> 1;
                end
            end else if (is_tmo) begin
                m_state = 4;
            end else if (is_wd) begin
                m_state = 5;
            end
        end
    endtask

    task automatic check_outputs();
        check({tag, ".status"}, 64'(status), 64'(m_state));
        check({tag, ".done"}, 64'(done), 64'(m_state >= 2));
        check({tag, ".pass"}, 64'(pass), 64'(m_state == 2));
        check({tag, ".core_reset"}, 64'(core_reset), 64'(m_state == 0));
        check({tag, ".cycle_count"}, 64'(cycle_count), 64'(m_cyc));
        check({tag, ".retire_count"}, 64'(retire_count), 64'(m_ret));
        check({tag, ".fail_testnum"}, 64'(fail_testnum), 64'(m_testnum));
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] gp);
        @(negedge clk);
        retire_valid = v;
        retire_pc    = pc;
        retire_inst  = inst;
        gp_value     = gp;
        model_step(v, pc, inst, gp);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, $urandom);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        x = $urandom;
        if (x == ECALL) x = 32'h0000_0013;
        return x;
    endfunction

    // Asserts reset between edges and checks the asynchronous effect before the next edge.
    task automatic do_reset(input string name);
        tag = name;
        @(posedge clk);
        #3;
        reset_n      = 1'b0;
        retire_valid = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic leave_hold();
        for (int i = 0; i < int'(RESET_CYCLES); i++) step(1'b0, 32'h0, 32'h0, 32'h1);
    endtask

    initial begin
        model_reset();
        #2;

        // Reset sequencing; retires during HOLD must be ignored.
        do_reset("reset");
        step(1'b1, 32'h0000_0200, ECALL, 32'h1);
        step(1'b1, 32'h0000_0200, ECALL, 32'h1);
        tag = "run_start";
        idle(2);

        // Ten distinct retires then ECALL with gp=1.
        do_reset("ecall_pass");
        leave_hold();
        for (int i = 0; i < 10; i++) step(1'b1, 32'h1000 + 32'(4 * i), rand_inst(), $urandom);
        step(1'b1, 32'h2000, ECALL, 32'h1);
        idle(3);

        // ECALL with gp=7 -> FAIL testnum 3, counters frozen afterwards.
        do_reset("ecall_fail");
        leave_hold();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h3000 + 32'(4 * i), rand_inst(), 32'h7);
        step(1'b1, 32'h3100, ECALL, 32'h7);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h3200 + 32'(4 * i), rand_inst(), 32'h7);

        // Four identical retires halt; an interrupted run of three does not.
        do_reset("loop_pass");
        leave_hold();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100, rand_inst(), 32'h1);
        idle(2);
        do_reset("loop_short");
        leave_hold();
        step(1'b1, 32'h100, rand_inst(), 32'h9);
        step(1'b1, 32'h104, rand_inst(), 32'h9);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100, rand_inst(), 32'h9);
        idle(3);
        step(1'b1, 32'h100, rand_inst(), 32'h9);
        idle(2);

        // Watchdog: 63 quiet cycles survive, 64 do not.
        do_reset("wdog");
        leave_hold();
        idle(int'(WDOG_CYCLES) - 1);
        step(1'b1, 32'h400, rand_inst(), 32'h1);
        idle(int'(WDOG_CYCLES) + 2);

        // Timeout with retires every cycle.
        do_reset("timeout");
        leave_hold();
        for (int i = 0; i < int'(TIMEOUT_CYCLES) + 3; i++)
            step(1'b1, 32'h8000 + 32'(4 * i), rand_inst(), 32'h1);

        // ECALL on the timeout cycle wins.
        do_reset("ecall_vs_timeout");
        leave_hold();
        for (int i = 0; i < int'(TIMEOUT_CYCLES) - 1; i++)
            step(1'b1, 32'h8000 + 32'(4 * i), rand_inst(), 32'h5);
        step(1'b1, 32'hA000, ECALL, 32'h5);
        idle(2);

        // Asynchronous reset mid-run, then a clean rerun.
        do_reset("midrun");
        leave_hold();
        for (int i = 0; i < 30; i++) step(1'b1, 32'h500 + 32'(4 * i), rand_inst(), 32'h1);
        do_reset("rerun");
        leave_hold();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h600 + 32'(4 * i), rand_inst(), 32'h1);
        step(1'b1, 32'h700, ECALL, 32'h1);
        idle(2);

        // Random runs over a small pc set so loops, ECALLs and quiet gaps mix.
        for (int r = 0; r < 6; r++) begin
            do_reset($sformatf("random%0d", r));
            leave_hold();
            for (int c = 0; c < int'(TIMEOUT_CYCLES) + 2 && m_state < 2; c++) begin
                logic        v;
                logic [31:0] pc, inst, gp;
                v    = ($urandom_range(0, 3) != 0);
                pc   = 32'h100 + 32'(4 * $urandom_range(0, 2));
                inst = ($urandom_range(0, 39) == 0) ? ECALL : rand_inst();
                gp   = ($urandom_range(0, 1) == 0) ? 32'h1 : $urandom;
                step(v, pc, inst, gp);
            end
            idle(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
